multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Parametrised successor to the combinational instruction decoder. It owns the fetch/execute phase sequencer, the instruction register, a configurable multiplier wait, hardware stack occupancy tracking and halt handling. It decodes the same 16-bit ISA into datapath enables for the four-register CPU. It sits between instruction memory and the datapath, and replaces the external fe/e1/e2 phase generator and the stackFull/stackEmpty logic.

## Interface
- MUL_LAT, 1: multiplier result latency in cycles (1..15); MLR spends MUL_LAT-1 extra WAIT cycles before EXEC2.
- STACK_DEPTH, 8: hardware stack entries (2..255).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freezes state, counters and IR; all write/enable outputs forced 0.
- instr_in  in  16  instruction memory read data, valid in FETCH.
- eq  in  1  ALU equality flag for JEQ/JNQ.
- jmr_cond  in  1  condition for JMR.
- fe, e1, e2, wait_ph  out  1 each  one-hot phase indicators.
- halted  out  1  high in HALT state.
- ir  out  16  latched instruction.
- reg_we  out  4  one-hot register write enables R0..R3.
- mux1_sel  out  2  write-back source: 00 memory, 01 immediate, 10 ALU, 11 stack.
- mux2_sel  out  1  address source register (LDR/STI in EXEC1).
- out_sel  out  2  register selected onto store/jump bus.
- pcmux_sel  out  2  00 immediate, 01 register (JMR), 10 stack (POP PC).
- pc_sload, pc_cnten, instr_rden, data_wren, carry_en, push_en, pop_en  out  1 each.
- stack_full, stack_empty  out  1 each  from occupancy counter.

## Operation
- Opcode = ir[15:11]. STP 00000, ADR 00001, ADM 0001x, ADI 00100, SBR 00101, SBM 0011x, SBI 01000, MLR 01001, XSL 01010, XSR 01011, BBO 01100, STK 01101 (ir[10]=1 pop, else push), LDR 01110, STI 01111, LDI 100xx, STA 101xx, LDA 110xx, JMR 11100, JMP 11101, JEQ 11110, JNQ 11111.
- Destination register: ADR/SBR/BBO/XSL/XSR/MLR use ir[3:2]; ADI/SBI/LDR use ir[10:9]; LDI/LDA use ir[12:11]; ADM/SBM use {0,ir[11]}; POP uses ir[8:7] when ir[9]=0.
- States: FETCH, EXEC1, WAIT, EXEC2, HALT.
  - FETCH -> EXEC1, with ir <= instr_in.
  - EXEC1 -> HALT on STP.
  - EXEC1 -> WAIT on MLR when MUL_LAT>1.
  - EXEC1 -> EXEC2 on LDA, LDR, ADM, SBM, and on MLR when MUL_LAT=1.
  - EXEC1 -> FETCH otherwise.
  - WAIT counts MUL_LAT-1 cycles, then -> EXEC2.
  - EXEC2 -> FETCH.
  - HALT is held until reset.
- Write enables:
  - reg_we fires in EXEC1 for ALU-immediate, ALU-register, LDI and POP-to-register.
  - reg_we fires in EXEC2 for LDA, LDR, ADM, SBM and MLR.
- mux1_sel:
  - 01 for LDI in EXEC1.
  - 10 for ALU writes.
  - 11 for POP-to-register.
  - 00 otherwise.
- carry_en:
  - ADR/SBR/XSL/XSR in EXEC1 when ir[10]=1.
  - ADI/SBI in EXEC1.
  - ADM/SBM in EXEC2.
  - MLR in EXEC2 when ir[10]=1.
- data_wren: STA or STI in EXEC1.
- out_sel: ir[12:11] for STA, ir[10:9] for STI, ir[1:0] for JMR, else 0.
- pc_sload (EXEC1 only): JMP, JEQ&eq, JNQ&~eq, JMR&jmr_cond, and POP-to-PC (ir[9:7]=100) when not empty.
- pc_cnten: FETCH, EXEC2, and EXEC1 when neither STP nor an EXEC2 op. Never asserted in WAIT or HALT.
- instr_rden: same as pc_cnten.
- Stack occupancy counter sp_cnt (0..STACK_DEPTH):
  - push_en = PUSH & EXEC1 & ~stack_full; increments sp_cnt.
  - pop_en = POP & EXEC1 & ~stack_empty; decrements sp_cnt.
  - PUSH when full or POP when empty is a no-op: no enable, no register write, no PC load, counter held.
  - stack_full = (sp_cnt==STACK_DEPTH); stack_empty = (sp_cnt==0).

## Timing
- On reset:
  - state=FETCH, ir=0, sp_cnt=0, WAIT counter=0.
  - fe=1; all other phase outputs 0; halted=0.
  - stack_empty=1, stack_full=0.
  - All enables 0 except pc_cnten and instr_rden, which are 1 because the state is FETCH.
- Reset wins over stall and over any in-progress WAIT, and clears HALT.
- All decode outputs are combinational from state and ir. They have no dependence on instr_in except through the IR capture at the end of FETCH.
- Cycles per instruction:
  - 2 for simple ops.
  - 3 for LDA, LDR, ADM and SBM.
  - 2+MUL_LAT for MLR.
  - STP reaches HALT after 2 cycles.
- stall high: state, ir, sp_cnt and the WAIT counter all hold. reg_we, data_wren, push_en, pop_en, pc_sload, pc_cnten, instr_rden and carry_en are all 0. Phase outputs keep showing the frozen state.

## Test plan
- Reset, then LDI R2 (0x9000|{12:11}=10) -> fe, e1, fe; reg_we=0100 and mux1_sel=01 in e1; pc_cnten=1 in both cycles.
- MLR with MUL_LAT=4, dest ir[3:2]=11 -> sequence fe, e1, wait×3, e2; reg_we=1000 only in e2; pc_cnten=0 during wait.
- Nine PUSHes with STACK_DEPTH=8 -> push_en on the first 8 only; stack_full=1 after the 8th; the 9th has no push_en and sp_cnt stays 8.
- POP to PC on an empty stack -> pc_sload=0, pop_en=0, pcmux_sel=00. After one PUSH, the same POP -> pc_sload=1, pcmux_sel=10, stack_empty=1 afterwards.
- JEQ with eq=0 -> pc_sload=0; with eq=1 -> pc_sload=1. JMR with jmr_cond=1 and ir[1:0]=10 -> out_sel=10, pcmux_sel=01.
- STP -> halted=1 from the third cycle, with all enables 0. Stall asserted mid-LDA e2 -> state holds and reg_we=0. Reset during WAIT -> fe=1 on the next cycle and sp_cnt=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Fetch/execute sequencer and instruction decoder for the four-register
// 16-bit CPU. Owns the instruction register, the multiplier wait counter, the
// hardware stack occupancy counter and the halt state. Every decode output is
// combinational from the current state and the latched instruction.
//
// Parameters
//   MUL_LAT      multiplier latency in cycles (1..15); MLR spends MUL_LAT-1
//                cycles in WAIT before EXEC2
//   STACK_DEPTH  hardware stack entries (2..255)
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   stall               freezes all state and forces enables low
//   instr_in[15:0]      instruction memory read data, captured in FETCH
//   eq, jmr_cond        branch conditions for JEQ/JNQ and JMR
//   fe/e1/e2/wait_ph    one-hot phase indicators; halted in HALT
//   ir[15:0]            latched instruction
//   reg_we[3:0]         one-hot register write enables R0..R3
//   mux1_sel[1:0]       write-back source: 00 mem, 01 imm, 10 ALU, 11 stack
//   mux2_sel            register as memory address (LDR/STI)
//   out_sel[1:0]        register driven onto the store/jump bus
//   pcmux_sel[1:0]      PC load source: 00 imm, 01 register, 10 stack
//   pc_sload, pc_cnten, instr_rden, data_wren, carry_en, push_en, pop_en
//   stack_full, stack_empty
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int MUL_LAT     = 1,
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [15:0] instr_in,
  input  logic        eq,
  input  logic        jmr_cond,
  output logic        fe,
  output logic        e1,
  output logic        e2,
  output logic        wait_ph,
  output logic        halted,
  output logic [15:0] ir,
  output logic [3:0]  reg_we,
  output logic [1:0]  mux1_sel,
  output logic        mux2_sel,
  output logic [1:0]  out_sel,
  output logic [1:0]  pcmux_sel,
  output logic        pc_sload,
  output logic        pc_cnten,
  output logic        instr_rden,
  output logic        data_wren,
  output logic        carry_en,
  output logic        push_en,
  output logic        pop_en,
  output logic        stack_full,
  output logic        stack_empty
);

  localparam int              SP_W      = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE    = SP_W'(1);
  localparam bit              HAS_WAIT  = (MUL_LAT > 1);
  // Last value of the wait counter before moving on to EXEC2.
  localparam logic [3:0]      WAIT_LAST = 4'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_WAIT,
    S_EXEC2,
    S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [SP_W-1:0] sp_cnt;
  logic [3:0]      wait_cnt;

  // ---------------------------------------------------------------- decode
  logic [4:0] op;
  logic op_stp, op_adr, op_adm, op_adi, op_sbr, op_sbm, op_sbi, op_mlr;
  logic op_xsl, op_xsr, op_bbo, op_push, op_pop, op_ldr, op_sti;
  logic op_ldi, op_sta, op_lda, op_jmr, op_jmp, op_jeq, op_jnq;
  logic pop_pc, pop_reg, alu_e1, mem_e2;
  logic [1:0] dest;

  assign op      = ir[15:11];
  assign op_stp  = (op == 5'b00000);
  assign op_adr  = (op == 5'b00001);
  assign op_adm  = (op[4:1] == 4'b0001);
  assign op_adi  = (op == 5'b00100);
  assign op_sbr  = (op == 5'b00101);
  assign op_sbm  = (op[4:1] == 4'b0011);
  assign op_sbi  = (op == 5'b01000);
  assign op_mlr  = (op == 5'b01001);
  assign op_xsl  = (op == 5'b01010);
  assign op_xsr  = (op == 5'b01011);
  assign op_bbo  = (op == 5'b01100);
  assign op_push = (op == 5'b01101) & ~ir[10];
  assign op_pop  = (op == 5'b01101) &  ir[10];
  assign op_ldr  = (op == 5'b01110);
  assign op_sti  = (op == 5'b01111);
  assign op_ldi  = (op[4:2] == 3'b100);
  assign op_sta  = (op[4:2] == 3'b101);
  assign op_lda  = (op[4:2] == 3'b110);
  assign op_jmr  = (op == 5'b11100);
  assign op_jmp  = (op == 5'b11101);
  assign op_jeq  = (op == 5'b11110);
  assign op_jnq  = (op == 5'b11111);

  assign pop_pc  = op_pop & (ir[9:7] == 3'b100);
  assign pop_reg = op_pop & ~ir[9];
  // ALU results written back at the end of EXEC1.
  assign alu_e1  = op_adi | op_sbi | op_adr | op_sbr | op_xsl | op_xsr | op_bbo;
  // Ops that need a second execute cycle (memory read or memory operand).
  assign mem_e2  = op_lda | op_ldr | op_adm | op_sbm;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    dest = 2'b00;
    if (op_adr | op_sbr | op_bbo | op_xsl | op_xsr | op_mlr) dest = ir[3:2];
    else if (op_adi | op_sbi | op_ldr)                       dest = ir[10:9];
    else if (op_ldi | op_lda)                                dest = ir[12:11];
    else if (op_adm | op_sbm)                                dest = {1'b0, ir[11]};
    else if (pop_reg)                                        dest = ir[8:7];
  end

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (reset)       state <= S_FETCH;
    else if (!stall) state <= state_nxt;
  end

  // IR, stack occupancy and wait counter share the freeze-on-stall rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir       <= '0;
      sp_cnt   <= '0;
      wait_cnt <= '0;
    end else if (!stall) begin
      if (state == S_FETCH) ir <= instr_in;
      if (state == S_WAIT)
        wait_cnt <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
      if (push_en)     sp_cnt <= sp_cnt + SP_ONE;
      else if (pop_en) sp_cnt <= sp_cnt - SP_ONE;
    end
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (op_stp)      state_nxt = S_HALT;
        else if (op_mlr) state_nxt = HAS_WAIT ? S_WAIT : S_EXEC2;
        else if (mem_e2) state_nxt = S_EXEC2;
        else             state_nxt = S_FETCH;
      end
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = S_EXEC2;
      S_EXEC2: state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  logic in_fe, in_e1, in_e2, live;

  assign in_fe       = (state == S_FETCH);
  assign in_e1       = (state == S_EXEC1);
  assign in_e2       = (state == S_EXEC2);
  assign live        = ~stall;

  assign fe          = in_fe;
  assign e1          = in_e1;
  assign e2          = in_e2;
  assign wait_ph     = (state == S_WAIT);
  assign halted      = (state == S_HALT);
  assign stack_full  = (sp_cnt == SP_FULL);
  assign stack_empty = (sp_cnt == '0);

  always_comb begin
    reg_we     = 4'b0000;
    mux1_sel   = 2'b00;
    mux2_sel   = 1'b0;
    out_sel    = 2'b00;
    pcmux_sel  = 2'b00;
    pc_sload   = 1'b0;
    pc_cnten   = 1'b0;
    data_wren  = 1'b0;
    carry_en   = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;

    if (op_sta)      out_sel = ir[12:11];
    else if (op_sti) out_sel = ir[10:9];
    else if (op_jmr) out_sel = ir[1:0];

    if (in_e1) begin
      if (op_ldi)                          mux1_sel = 2'b01;
      else if (alu_e1)                     mux1_sel = 2'b10;
      else if (pop_reg & ~stack_empty)     mux1_sel = 2'b11;
      mux2_sel = op_ldr | op_sti;
      if (op_jmr)                          pcmux_sel = 2'b01;
      else if (pop_pc & ~stack_empty)      pcmux_sel = 2'b10;
    end else if (in_e2) begin
      if (op_adm | op_sbm | op_mlr)        mux1_sel = 2'b10;
    end

    if (live) begin
      if ((in_e1 & (alu_e1 | op_ldi | (pop_reg & ~stack_empty))) |
          (in_e2 & (mem_e2 | op_mlr)))
        reg_we = 4'b0001 << dest;

      pc_cnten = in_fe | in_e2 | (in_e1 & ~op_stp & ~mem_e2 & ~op_mlr);

      if (in_e1) begin
        pc_sload  = op_jmp | (op_jeq & eq) | (op_jnq & ~eq) |
                    (op_jmr & jmr_cond) | (pop_pc & ~stack_empty);
        data_wren = op_sta | op_sti;
        carry_en  = ((op_adr | op_sbr | op_xsl | op_xsr) & ir[10]) | op_adi | op_sbi;
        push_en   = op_push & ~stack_full;
        pop_en    = op_pop & ~stack_empty;
      end else if (in_e2) begin
        carry_en  = op_adm | op_sbm | (op_mlr & ir[10]);
      end
    end
  end

  assign instr_rden = pc_cnten;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed scenarios followed by random instruction streams with random
// stalls, branch flags and resets. A mnemonic-level reference model predicts
// every output for each cycle; the driver queues the prediction and a
// separate monitor compares it against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int MUL_LAT     = 4;
  localparam int STACK_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, stall, eq, jmr_cond;
  logic [15:0] instr_in;
  logic        fe, e1, e2, wait_ph, halted;
  logic [15:0] ir;
  logic [3:0]  reg_we;
  logic [1:0]  mux1_sel, out_sel, pcmux_sel;
  logic        mux2_sel, pc_sload, pc_cnten, instr_rden, data_wren;
  logic        carry_en, push_en, pop_en, stack_full, stack_empty;

  multicycle_control_unit #(
    .MUL_LAT    (MUL_LAT),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .instr_in   (instr_in),
    .eq         (eq),
    .jmr_cond   (jmr_cond),
    .fe         (fe),
    .e1         (e1),
    .e2         (e2),
    .wait_ph    (wait_ph),
    .halted     (halted),
    .ir         (ir),
    .reg_we     (reg_we),
    .mux1_sel   (mux1_sel),
    .mux2_sel   (mux2_sel),
    .out_sel    (out_sel),
    .pcmux_sel  (pcmux_sel),
    .pc_sload   (pc_sload),
    .pc_cnten   (pc_cnten),
    .instr_rden (instr_rden),
    .data_wren  (data_wren),
    .carry_en   (carry_en),
    .push_en    (push_en),
    .pop_en     (pop_en),
    .stack_full (stack_full),
    .stack_empty(stack_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fe, e1, e2, wt, halted;
    logic [15:0] ir;
    logic [3:0]  reg_we;
    logic [1:0]  mux1;
    logic        mux2;
    logic [1:0]  out_sel, pcmux;
    logic        sload, cnten, rden, dwren, carry, push, pop, full, empty;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;

  // Reference model: current instruction, cycle index within it, halt flag
  // and number of occupied stack entries.
  logic [15:0] m_ir;
  int          m_step;
  bit          m_halt;
  int          m_sp;

  function automatic string mnem(logic [15:0] w);
    casez (w[15:11])
      5'b00000: return "STP";
      5'b00001: return "ADR";
      5'b0001?: return "ADM";
      5'b00100: return "ADI";
      5'b00101: return "SBR";
      5'b0011?: return "SBM";
      5'b01000: return "SBI";
      5'b01001: return "MLR";
      5'b01010: return "XSL";
      5'b01011: return "XSR";
      5'b01100: return "BBO";
      5'b01101: return w[10] ? "POP" : "PUSH";
      5'b01110: return "LDR";
      5'b01111: return "STI";
      5'b100??: return "LDI";
      5'b101??: return "STA";
      5'b110??: return "LDA";
      5'b11100: return "JMR";
      5'b11101: return "JMP";
      5'b11110: return "JEQ";
      default:  return "JNQ";
    endcase
  endfunction

  function automatic int cpi(string m);
    if (m == "LDA" || m == "LDR" || m == "ADM" || m == "SBM") return 3;
    if (m == "MLR") return 2 + MUL_LAT;
    return 2;
  endfunction

  function automatic string phase_of();
    if (m_halt)       return "HALT";
    if (m_step == 0)  return "FE";
    if (m_step == 1)  return "E1";
    if (mnem(m_ir) == "MLR" && m_step <= MUL_LAT) return "WT";
    return "E2";
  endfunction

  function automatic logic [1:0] dest_of(logic [15:0] w);
    string m;
    m = mnem(w);
    if (m == "ADR" || m == "SBR" || m == "BBO" || m == "XSL" || m == "XSR" || m == "MLR")
      return w[3:2];
    if (m == "ADI" || m == "SBI" || m == "LDR") return w[10:9];
    if (m == "LDI" || m == "LDA")               return w[12:11];
    if (m == "ADM" || m == "SBM")               return {1'b0, w[11]};
    if (m == "POP")                             return w[8:7];
    return 2'b00;
  endfunction

  function automatic obs_t model_outputs(bit stl, bit e, bit j);
    obs_t  o;
    string m, ph;
    bit    live, nonempty, full, alu1, popreg, poppc, wr1, wr2, ex1, ex2;
    m        = mnem(m_ir);
    ph       = phase_of();
    ex1      = (ph == "E1");
    ex2      = (ph == "E2");
    live     = !stl;
    nonempty = (m_sp > 0);
    full     = (m_sp == STACK_DEPTH);
    alu1     = (m == "ADI" || m == "SBI" || m == "ADR" || m == "SBR" ||
                m == "XSL" || m == "XSR" || m == "BBO");
    popreg   = (m == "POP") && !m_ir[9];
    poppc    = (m == "POP") && (m_ir[9:7] == 3'b100);
    wr1      = alu1 || m == "LDI" || (popreg && nonempty);
    wr2      = (m == "LDA" || m == "LDR" || m == "ADM" || m == "SBM" || m == "MLR");

    o        = '0;
    o.fe     = (ph == "FE");
    o.e1     = ex1;
    o.e2     = ex2;
    o.wt     = (ph == "WT");
    o.halted = (ph == "HALT");
    o.ir     = m_ir;
    if (live && ((ex1 && wr1) || (ex2 && wr2))) o.reg_we = 4'b0001 << dest_of(m_ir);
    if (ex1) begin
      if (m == "LDI")               o.mux1 = 2'b01;
      else if (alu1)                o.mux1 = 2'b10;
      else if (popreg && nonempty)  o.mux1 = 2'b11;
      if (m == "JMR")               o.pcmux = 2'b01;
      else if (poppc && nonempty)   o.pcmux = 2'b10;
      o.mux2 = (m == "LDR" || m == "STI");
    end
    if (ex2 && (m == "ADM" || m == "SBM" || m == "MLR")) o.mux1 = 2'b10;
    if (m == "STA")      o.out_sel = m_ir[12:11];
    else if (m == "STI") o.out_sel = m_ir[10:9];
    else if (m == "JMR") o.out_sel = m_ir[1:0];
    o.sload = live && ex1 && (m == "JMP" || (m == "JEQ" && e) || (m == "JNQ" && !e) ||
                              (m == "JMR" && j) || (poppc && nonempty));
    o.cnten = live && ((ph == "FE") || ex2 || (ex1 && m != "STP" && cpi(m) == 2));
    o.rden  = o.cnten;
    o.dwren = live && ex1 && (m == "STA" || m == "STI");
    o.carry = live && ((ex1 && (m == "ADR" || m == "SBR" || m == "XSL" || m == "XSR") && m_ir[10]) ||
                       (ex1 && (m == "ADI" || m == "SBI")) ||
                       (ex2 && (m == "ADM" || m == "SBM")) ||
                       (ex2 && m == "MLR" && m_ir[10]));
    o.push  = live && ex1 && (m == "PUSH") && !full;
    o.pop   = live && ex1 && (m == "POP") && nonempty;
    o.full  = full;
    o.empty = !nonempty;
    return o;
  endfunction

  task automatic model_update(input bit rst, input bit stl, input logic [15:0] w);
    string m;
    if (rst) begin
      m_ir = '0; m_step = 0; m_halt = 0; m_sp = 0;
      return;
    end
    if (stl || m_halt) return;
    if (m_step == 0) begin
      m_ir   = w;
      m_step = 1;
      return;
    end
    m = mnem(m_ir);
    if (m_step == 1) begin
      if (m == "STP") begin
        m_halt = 1; m_step = 0;
        return;
      end
      if (m == "PUSH" && m_sp < STACK_DEPTH) m_sp++;
      if (m == "POP"  && m_sp > 0)           m_sp--;
    end
    m_step++;
    if (m_step == cpi(m)) m_step = 0;
  endtask

  task automatic check(input string name, input obs_t act, input obs_t expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue the prediction, advance the model.
  task automatic do_cycle(input bit rst, input bit stl, input logic [15:0] w,
                          input bit e, input bit j);
    reset    = rst;
    stall    = stl;
    instr_in = w;
    eq       = e;
    jmr_cond = j;
    exp_q.push_back(model_outputs(stl, e, j));
    tag_q.push_back($sformatf("cyc%0d %s %s%s", cyc, mnem(m_ir), phase_of(), stl ? " stall" : ""));
    cyc++;
    @(posedge clk);
    model_update(rst, stl, w);
    #1;
  endtask

  // Runs one instruction to completion; eqv/jv < 0 pick random flags.
  task automatic exec_instr(input logic [15:0] w, input int stall_pct,
                            input int eqv, input int jv);
    int guard;
    bit stl, e, j;
    guard = 0;
    do begin
      stl = ($urandom_range(99) < stall_pct);
      e   = (eqv < 0) ? 1'($urandom_range(1)) : 1'(eqv);
      j   = (jv  < 0) ? 1'($urandom_range(1)) : 1'(jv);
      do_cycle(1'b0, stl, w, e, j);
      guard++;
    end while (m_step == 0 && !m_halt && guard < 40);
    while (m_step != 0 && !m_halt && guard < 80) begin
      stl = ($urandom_range(99) < stall_pct);
      e   = (eqv < 0) ? 1'($urandom_range(1)) : 1'(eqv);
      j   = (jv  < 0) ? 1'($urandom_range(1)) : 1'(jv);
      do_cycle(1'b0, stl, 16'($urandom), e, j);
      guard++;
    end
    if (guard >= 80) begin
      n_checks++;
      n_errors++;
      $display("FAIL instr %h: did not complete within %0d cycles", w, guard);
    end
  endtask

  // Monitor: the decode outputs are presented every cycle.
  always @(negedge clk) begin
    obs_t act;
    if (exp_q.size() != 0) begin
      act.fe      = fe;         act.e1    = e1;        act.e2    = e2;
      act.wt      = wait_ph;    act.halted = halted;   act.ir    = ir;
      act.reg_we  = reg_we;     act.mux1  = mux1_sel;  act.mux2  = mux2_sel;
      act.out_sel = out_sel;    act.pcmux = pcmux_sel; act.sload = pc_sload;
      act.cnten   = pc_cnten;   act.rden  = instr_rden; act.dwren = data_wren;
      act.carry   = carry_en;   act.push  = push_en;   act.pop   = pop_en;
      act.full    = stack_full; act.empty = stack_empty;
      check(tag_q.pop_front(), act, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    reset = 1'b1; stall = 1'b0; instr_in = '0; eq = 1'b0; jmr_cond = 1'b0;
    @(posedge clk);
    model_update(1'b1, 1'b0, '0);
    #1;
    do_cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);   // reset under stall

    // LDI R2, then MLR R3 without and with carry.
    exec_instr(16'h9000, 0, 0, 0);
    exec_instr(16'h480C, 0, 0, 0);
    exec_instr(16'h4C0C, 0, 0, 0);

    // Fill the stack past capacity, drain it, then pop once more.
    repeat (9) exec_instr(16'h6800, 0, 0, 0);
    for (int i = 0; i < 8; i++) exec_instr(16'h6C00 | 16'(i << 7), 0, 0, 0);
    exec_instr(16'h6C80, 0, 0, 0);
    exec_instr(16'h6F80, 0, 0, 0);

    // POP to PC on empty, then after one PUSH.
    exec_instr(16'h6E00, 0, 0, 0);
    exec_instr(16'h6800, 0, 0, 0);
    exec_instr(16'h6E00, 0, 0, 0);

    // Branches.
    exec_instr(16'hF000, 0, 0, 0);
    exec_instr(16'hF000, 0, 1, 0);
    exec_instr(16'hF800, 0, 0, 0);
    exec_instr(16'hF800, 0, 1, 0);
    exec_instr(16'hE002, 0, 0, 1);
    exec_instr(16'hE002, 0, 0, 0);
    exec_instr(16'hE800, 0, 0, 0);

    // Remaining op classes.
    exec_instr(16'hB800, 0, 0, 0);   // STA R3
    exec_instr(16'h7C00, 0, 0, 0);   // STI R2
    exec_instr(16'hC800, 0, 0, 0);   // LDA R1
    exec_instr(16'h7600, 0, 0, 0);   // LDR R3
    exec_instr(16'h1800, 0, 0, 0);   // ADM R1
    exec_instr(16'h3000, 0, 0, 0);   // SBM R0
    exec_instr(16'h0C08, 0, 0, 0);   // ADR R2 with carry
    exec_instr(16'h2804, 0, 0, 0);   // SBR R1
    exec_instr(16'h5404, 0, 0, 0);   // XSL R1 with carry
    exec_instr(16'h580C, 0, 0, 0);   // XSR R3
    exec_instr(16'h6008, 0, 0, 0);   // BBO R2
    exec_instr(16'h2200, 0, 0, 0);   // ADI R1
    exec_instr(16'h4600, 0, 0, 0);   // SBI R3

    // Stall in the middle of LDA's EXEC2.
    do_cycle(1'b0, 1'b0, 16'hC800, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 16'hDEF0, 1'b0, 1'b0);

    // Reset while in WAIT with entries on the stack.
    exec_instr(16'h6800, 0, 0, 0);
    exec_instr(16'h6800, 0, 0, 0);
    do_cycle(1'b0, 1'b0, 16'h480C, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    exec_instr(16'h9800, 0, 0, 0);

    // Random streams with stalls, resets and the occasional halt.
    for (int i = 0; i < 400; i++) begin
      w = 16'($urandom);
      if ($urandom_range(99) < 3) begin
        do_cycle(1'b1, 1'($urandom_range(1)), w, 1'b0, 1'b0);
      end else begin
        exec_instr(w, 10, -1, -1);
        if (m_halt) begin
          repeat (2) do_cycle(1'b0, 1'($urandom_range(1)), 16'($urandom),
                              1'($urandom_range(1)), 1'($urandom_range(1)));
          do_cycle(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        end
      end
    end

    // Final STP and a few halted cycles.
    exec_instr(16'h0000, 0, 0, 0);
    repeat (3) do_cycle(1'b0, 1'($urandom_range(1)), 16'($urandom),
                        1'($urandom_range(1)), 1'($urandom_range(1)));

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
